// File: rtl/exe_stage.sv
// ---------------------------------------------------------------------------
// exe_stage -- execute stage of the 5-stage MIPS pipeline.
//
// This stage holds one instruction from decode and computes its ALU result
// in a single cycle. For lw/sw it also issues the data-SRAM request. It
// offers the result to the memory stage and reports forwarding and
// load-hazard information back to decode.
//
// Ports
//   clk              in   rising-edge clock
//   reset            in   asynchronous, active-high reset
//   ms_allowin       in   memory stage can accept an instruction this cycle
//   es_allowin       out  this stage can accept an instruction
//   ds_to_es_valid   in   decode presents a valid instruction
//   ds_to_es_bus     in   decode bus; fields are listed at the slice below
//   es_to_ms_valid   out  valid instruction offered to the memory stage
//   es_to_ms_bus     out  {res_from_mem, gr_we, dest[4:0], alu_result, pc}
//   es_fwd_bus       out  {es_load, es_res[31:0], es_dest[4:0]}
//   data_sram_en     out  data SRAM access enable
//   data_sram_wen    out  byte write enables (all four bytes for sw)
//   data_sram_addr   out  byte address (the ALU result)
//   data_sram_wdata  out  store data (rt value)
// ---------------------------------------------------------------------------
module exe_stage #(
    parameter int DS_TO_ES_BUS_WD = 136,
    parameter int ES_TO_MS_BUS_WD = 71
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ms_allowin,
    output logic                       es_allowin,
    input  logic                       ds_to_es_valid,
    input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
    output logic                       es_to_ms_valid,
    output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic [37:0]                es_fwd_bus,
    output logic                       data_sram_en,
    output logic [3:0]                 data_sram_wen,
    output logic [31:0]                data_sram_addr,
    output logic [31:0]                data_sram_wdata
);

    // -----------------------------------------------------------------------
    // Pipeline register
    // -----------------------------------------------------------------------
    logic                       r_es_valid;
    logic [DS_TO_ES_BUS_WD-1:0] r_es_bus;

    logic w_es_ready_go;
    assign w_es_ready_go  = 1'b1;   // the ALU always finishes in one cycle
    assign es_allowin     = !r_es_valid || (w_es_ready_go && ms_allowin);
    assign es_to_ms_valid = r_es_valid && w_es_ready_go;

    // NOTE: state registers use non-blocking assignments, so every register
    // samples pre-edge values and the order of statements does not matter.
    // NOTE: the payload register is reset as well as the valid bit. This
    // makes every output bus read as zero during and after reset, instead of
    // showing stale fields.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_es_valid <= 1'b0;
            r_es_bus   <= '0;
        end else begin
            if (es_allowin) begin
                r_es_valid <= ds_to_es_valid;
            end
            if (ds_to_es_valid && es_allowin) begin
                r_es_bus <= ds_to_es_bus;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Decode-bus fields
    // -----------------------------------------------------------------------
    logic [11:0] w_alu_op;
    logic        w_load_op;
    logic        w_src1_is_sa;
    logic        w_src1_is_pc;
    logic        w_src2_is_imm;
    logic        w_src2_is_8;
    logic        w_gr_we;
    logic        w_mem_we;
    logic [4:0]  w_dest;
    logic [15:0] w_imm;
    logic [31:0] w_rs_value;
    logic [31:0] w_rt_value;
    logic [31:0] w_pc;

    assign w_alu_op      = r_es_bus[135:124];
    assign w_load_op     = r_es_bus[123];
    assign w_src1_is_sa  = r_es_bus[122];
    assign w_src1_is_pc  = r_es_bus[121];
    assign w_src2_is_imm = r_es_bus[120];
    assign w_src2_is_8   = r_es_bus[119];
    assign w_gr_we       = r_es_bus[118];
    assign w_mem_we      = r_es_bus[117];
    assign w_dest        = r_es_bus[116:112];
    assign w_imm         = r_es_bus[111:96];
    assign w_rs_value    = r_es_bus[95:64];
    assign w_rt_value    = r_es_bus[63:32];
    assign w_pc          = r_es_bus[31:0];

    // -----------------------------------------------------------------------
    // Operand selection
    // -----------------------------------------------------------------------
    logic [31:0] w_src1;
    logic [31:0] w_src2;

    // The shift amount of sll/srl/sra lives in imm[10:6] (the instr sa field).
    assign w_src1 = w_src1_is_sa ? {27'b0, w_imm[10:6]} :
                    w_src1_is_pc ? w_pc                 :
                                   w_rs_value;
    assign w_src2 = w_src2_is_imm ? {{16{w_imm[15]}}, w_imm} :
                    w_src2_is_8   ? 32'd8                    :
                                    w_rt_value;

    // -----------------------------------------------------------------------
    // ALU: one-hot operation select, results OR-ed together
    // -----------------------------------------------------------------------
    logic [31:0] w_add_res;
    logic [31:0] w_sub_res;
    logic        w_slt;
    logic        w_sltu;
    logic [4:0]  w_shamt;
    logic [31:0] w_sra_res;
    logic [31:0] w_alu_result;

    assign w_add_res = w_src1 + w_src2;
    assign w_sub_res = w_src1 - w_src2;
    assign w_slt     = $signed(w_src1) < $signed(w_src2);
    assign w_sltu    = w_src1 < w_src2;
    assign w_shamt   = w_src1[4:0];
    assign w_sra_res = $signed(w_src2) >>> w_shamt;

    // NOTE: the result gets a default before any conditional update, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_alu_result = '0;
        if (w_alu_op[0])  w_alu_result |= w_add_res;
        if (w_alu_op[1])  w_alu_result |= w_sub_res;
        if (w_alu_op[2])  w_alu_result |= {31'b0, w_slt};
        if (w_alu_op[3])  w_alu_result |= {31'b0, w_sltu};
        if (w_alu_op[4])  w_alu_result |= w_src1 & w_src2;
        if (w_alu_op[5])  w_alu_result |= ~(w_src1 | w_src2);
        if (w_alu_op[6])  w_alu_result |= w_src1 | w_src2;
        if (w_alu_op[7])  w_alu_result |= w_src1 ^ w_src2;
        if (w_alu_op[8])  w_alu_result |= w_src2 << w_shamt;
        if (w_alu_op[9])  w_alu_result |= w_src2 >> w_shamt;
        if (w_alu_op[10]) w_alu_result |= w_sra_res;
        if (w_alu_op[11]) w_alu_result |= {w_src2[15:0], 16'b0};
    end

    // -----------------------------------------------------------------------
    // Data-SRAM request
    // -----------------------------------------------------------------------
    // The request is tied to the cycle the instruction actually advances.
    // A stalled store therefore writes exactly once. Because r_es_valid is
    // cleared asynchronously, no enable can be asserted while reset is high.
    logic w_mem_go;
    assign w_mem_go        = r_es_valid && ms_allowin && (w_load_op || w_mem_we);
    assign data_sram_en    = w_mem_go;
    assign data_sram_wen   = (w_mem_go && w_mem_we) ? 4'hF : 4'h0;
    assign data_sram_addr  = w_alu_result;
    assign data_sram_wdata = w_rt_value;

    // -----------------------------------------------------------------------
    // Outgoing buses
    // -----------------------------------------------------------------------
    assign es_to_ms_bus = {w_load_op, w_gr_we, w_dest, w_alu_result, w_pc};

    // Decode treats dest 0 as "no hazard", so invalid or non-writing slots
    // report 0.
    assign es_fwd_bus = {r_es_valid && w_load_op,
                         w_alu_result,
                         (r_es_valid && w_gr_we) ? w_dest : 5'd0};

endmodule
